cla32_pipe: RTL and testbench



---
 rtl/alu_pkg.sv | 43 ++++
 rtl/cla32_pipe_blk_pg8.sv | 26 ++
 rtl/cla32_pipe.sv | 137 +++++++++++++
 tb/tb_cla32_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, the stage-1 register bundle of the pipelined
// CLA, and the in-block carry lookahead helper.
package alu_pkg;

  localparam int ALU_W    = 32;
  localparam int CLA_BLK  = 8;
  localparam int CLA_NBLK = 4;

  typedef struct packed {
    logic [ALU_W-1:0]    p;
    logic [ALU_W-1:0]    g;
    logic [ALU_W-1:0]    x;
    logic [CLA_NBLK-1:0] P;
    logic [CLA_NBLK-1:0] G;
    logic                cin;
    logic                a31;
    logic                bx31;
  } cla_s1_t;

  // Carry into each bit of one block, every term a full product from the block
  // carry-in or a lower generate, so the expansion is flat rather than a ripple.
  function automatic logic [CLA_BLK-1:0] cla_blk_carries(
    input logic [CLA_BLK-1:0] p,
    input logic [CLA_BLK-1:0] g,
    input logic               c0
  );
    logic [CLA_BLK-1:0] c;
    logic               term;
    c = '0;
    for (int j = 0; j < CLA_BLK; j++) begin
      term = c0;
      for (int m = 0; m < j; m++) term = term & p[m];
      c[j] = term;
      for (int k = 0; k < j; k++) begin
        term = g[k];
        for (int m = k + 1; m < j; m++) term = term & p[m];
        c[j] = c[j] | term;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/cla32_pipe_blk_pg8.sv
// 8-bit block propagate / group generate, purely combinational.
module blk_pg8
  import alu_pkg::*;
(
  input  logic [CLA_BLK-1:0] p,
  input  logic [CLA_BLK-1:0] g,
  output logic               bp,
  output logic               bg
);

  logic term;

  always_comb begin
    // NOTE: every output gets a default before the loops so no path leaves it
    // unassigned; otherwise the tool infers a latch.
    bp   = &p;
    bg   = 1'b0;
    term = 1'b0;
    for (int k = 0; k < CLA_BLK; k++) begin
      term = g[k];
      for (int m = k + 1; m < CLA_BLK; m++) term = term & p[m];
      bg = bg | term;
    end
  end

endmodule

// File: rtl/cla32_pipe.sv
// Two-stage pipelined 32-bit carry-lookahead adder/subtractor with valid/ready
// on both sides. Define CLA32_PIPE_FLAGS_EN to build the overflow/compare flags.
module cla32_pipe
  import alu_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ALU_W-1:0] opA,
  input  logic [ALU_W-1:0] opB,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ALU_W-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             isLessThan,
  output logic             isNotEqual
);

  logic             s1_valid;
  logic             s2_valid;
  logic             s1_advance;
  cla_s1_t          s1_d;
  cla_s1_t          s1_q;
  logic [ALU_W-1:0] bx;
  logic [ALU_W-1:0] p_w;
  logic [ALU_W-1:0] g_w;
  logic [CLA_NBLK-1:0] blk_p;
  logic [CLA_NBLK-1:0] blk_g;

  assign bx  = sub ? ~opB : opB;
  assign p_w = opA | bx;
  assign g_w = opA & bx;

  for (genvar k = 0; k < CLA_NBLK; k++) begin : g_blk
    blk_pg8 u_blk (
      .p  (p_w[k*CLA_BLK +: CLA_BLK]),
      .g  (g_w[k*CLA_BLK +: CLA_BLK]),
      .bp (blk_p[k]),
      .bg (blk_g[k])
    );
  end

  always_comb begin
    s1_d      = '0;
    s1_d.p    = p_w;
    s1_d.g    = g_w;
    s1_d.x    = opA ^ bx;
    s1_d.P    = blk_p;
    s1_d.G    = blk_g;
    s1_d.cin  = sub;
    s1_d.a31  = opA[ALU_W-1];
    s1_d.bx31 = bx[ALU_W-1];
  end

  assign s1_advance = s1_valid & (~s2_valid | out_ready);
  assign in_ready   = ~s1_valid | s1_advance;
  assign out_valid  = s2_valid;

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, regardless of statement order.
    if (reset) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  // Stage 2: block carry-ins by two-level lookahead, then per-bit expansion.
  logic [CLA_NBLK-1:0] cb;
  logic                c32;
  logic [ALU_W-1:0]    carry;
  logic [ALU_W-1:0]    sum_d;

  always_comb begin
    cb[0] = s1_q.cin;
    cb[1] = s1_q.G[0] | (s1_q.P[0] & s1_q.cin);
    cb[2] = s1_q.G[1] | (s1_q.P[1] & s1_q.G[0])
          | (s1_q.P[1] & s1_q.P[0] & s1_q.cin);
    cb[3] = s1_q.G[2] | (s1_q.P[2] & s1_q.G[1])
          | (s1_q.P[2] & s1_q.P[1] & s1_q.G[0])
          | (s1_q.P[2] & s1_q.P[1] & s1_q.P[0] & s1_q.cin);
    c32   = s1_q.G[3] | (s1_q.P[3] & s1_q.G[2])
          | (s1_q.P[3] & s1_q.P[2] & s1_q.G[1])
          | (s1_q.P[3] & s1_q.P[2] & s1_q.P[1] & s1_q.G[0])
          | (s1_q.P[3] & s1_q.P[2] & s1_q.P[1] & s1_q.P[0] & s1_q.cin);
    for (int k = 0; k < CLA_NBLK; k++) begin
      carry[k*CLA_BLK +: CLA_BLK] = cla_blk_carries(s1_q.p[k*CLA_BLK +: CLA_BLK],
                                                    s1_q.g[k*CLA_BLK +: CLA_BLK],
                                                    cb[k]);
    end
    sum_d = s1_q.x ^ carry;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
    end else if (s1_advance) begin
      s2_valid <= 1'b1;
      sum      <= sum_d;
      cout     <= c32;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

`ifdef CLA32_PIPE_FLAGS_EN
  logic ovf_d;
  assign ovf_d = (s1_q.a31 == s1_q.bx31) & (sum_d[ALU_W-1] != s1_q.a31);

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow   <= 1'b0;
      isLessThan <= 1'b0;
      isNotEqual <= 1'b0;
    end else if (s1_advance) begin
      overflow   <= ovf_d;
      isLessThan <= sum_d[ALU_W-1] ^ ovf_d;
      isNotEqual <= |sum_d;
    end
  end
`else
  logic unused_flag_inputs;
  assign unused_flag_inputs = s1_q.a31 ^ s1_q.bx31;
  assign overflow   = 1'b0;
  assign isLessThan = 1'b0;
  assign isNotEqual = 1'b0;
`endif

endmodule

// File: tb/tb_cla32_pipe.sv
// Scoreboard bench for cla32_pipe: directed corner cases, a backpressure
// stream, a random burst and reset with operands in flight.
module tb_cla32_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        overflow;
  logic        isLessThan;
  logic        isNotEqual;

  cla32_pipe dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opA        (opA),
    .opB        (opB),
    .sub        (sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .cout       (cout),
    .overflow   (overflow),
    .isLessThan (isLessThan),
    .isNotEqual (isNotEqual)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ov;
    logic        lt;
    logic        ne;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   bp_free = 1'b1;
  bit   saw_full = 1'b0;
  bit   rnd_done;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t        e;
    longint      sa;
    longint      sbv;
    longint      sr;
    logic [32:0] u;
    sa  = $signed(a);
    sbv = $signed(b);
    sr  = s ? sa - sbv : sa + sbv;
    u   = {1'b0, a} + {1'b0, b};
    e.sum  = sr[31:0];
    e.cout = s ? (a >= b) : u[32];
`ifdef CLA32_PIPE_FLAGS_EN
    e.ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.lt = (sr < 0);
    e.ne = (e.sum != 32'h0);
`else
    e.ov = 1'b0;
    e.lt = 1'b0;
    e.ne = 1'b0;
`endif
    e.acc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  // Drives one operand pair from a negedge and holds it until accepted; returns
  // at the negedge after the accepting edge with in_valid still high.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    bit   done;
    done     = 1'b0;
    in_valid = 1'b1;
    opA      = a;
    opB      = b;
    sub      = s;
    for (int t = 0; t < 60 && !done; t++) begin
      #3;
      if (in_ready) begin
        e     = model(a, b, s);
        e.acc = cyc;
        e.lat = bp_free;
        sb.push_back(e);
        done  = 1'b1;
      end
      @(negedge clock);
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clock);
      t++;
    end
    check("drain_empty", sb.size(), 32'd0);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"}, out_valid, 32'd0);
    check({tag, "_sum"}, sum, 32'd0);
    check({tag, "_flags"}, {cout, overflow, isLessThan, isNotEqual}, 32'd0);
  endtask

  // Monitor: in_ready against an occupancy model, output against the queue head.
  always begin
    exp_t e;
    @(negedge clock);
    #2;
    if (!reset) begin
      check("in_ready", in_ready, (sb.size() == 2 && !out_ready) ? 32'd0 : 32'd1);
      if (in_valid && !in_ready) saw_full = 1'b1;
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out", 32'd1, 32'd0);
        end else begin
          e = sb[0];
          check("sum", sum, e.sum);
          check("cout", cout, e.cout);
          check("overflow", overflow, e.ov);
          check("isLessThan", isLessThan, e.lt);
          check("isNotEqual", isNotEqual, e.ne);
          if (out_ready) begin
            void'(sb.pop_front());
            if (e.lat) check("latency", cyc - e.acc, 32'd2);
          end
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    opA       = '0;
    opB       = '0;
    sub       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clock);
    #1 check_idle_zero("reset");
    @(negedge clock);
    reset = 1'b0;
    #1 check("in_ready_after_reset", in_ready, 32'd1);

    // Directed corner cases, back to back, no backpressure.
    send(32'h0000_0005, 32'h0000_0003, 1'b0);
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    send(32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
    send(32'h8000_0000, 32'h0000_0001, 1'b1);
    send(32'h1234_5678, 32'h1234_5678, 1'b1);
    in_valid = 1'b0;
    drain();

    // Six-op stream with a three-cycle consumer stall in the middle.
    bp_free = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(32'h0100_0000 * i + 32'h00FF_00FF, 32'h0000_0101 * i, i[0]);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(negedge clock);
        out_ready = 1'b0;
        repeat (3) @(negedge clock);
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_fills_pipe", saw_full, 32'd1);

    // Random burst with random consumer readiness.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clock);
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two operands in flight: nothing may emerge afterwards.
    out_ready = 1'b0;
    send(32'h0000_0010, 32'h0000_0020, 1'b0);
    send(32'h0000_0030, 32'h0000_0040, 1'b1);
    in_valid = 1'b0;
    reset    = 1'b1;
    sb.delete();
    repeat (2) @(negedge clock);
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check_idle_zero("post_reset");
      @(negedge clock);
    end
    bp_free = 1'b1;
    send(32'h0000_0001, 32'h0000_0002, 1'b0);
    in_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
